// File: rtl/nv_nvdla_sync_req_ack_ctrl_pkg.sv
// Shared definitions for the req/ack clock-domain crossing controller:
// FSM state encoding and default data/timeout widths.
package nv_nvdla_sync_req_ack_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_DW   = 32;
    localparam int unsigned DEFAULT_TO_W = 8;

endpackage

// File: rtl/p_SSYNC2DO_C_PP.sv
// Two-flop synchronizer cell with asynchronous active-low clear.
module p_SSYNC2DO_C_PP (
    input  logic clk,
    input  logic d,
    input  logic clr_,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nv_nvdla_sync_req_ack_ctrl.sv
// Four-phase req/ack receiver: synchronizes a foreign request, presents the
// captured word as a local valid/ready transfer, and flags protocol/stall errors.
module nv_nvdla_sync_req_ack_ctrl
    import nv_nvdla_sync_req_ack_ctrl_pkg::*;
#(
    parameter int unsigned DW   = DEFAULT_DW,
    parameter int unsigned TO_W = DEFAULT_TO_W
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          src_req,
    input  logic [DW-1:0] src_data,
    output logic          dst_ack,
    output logic          dst_valid,
    input  logic          dst_ready,
    output logic [DW-1:0] dst_data,
    output logic          err_proto,
    output logic          err_timeout,
    input  logic          err_clr
);

    localparam logic [TO_W-1:0] TO_MAX = '1;
    localparam logic [TO_W-1:0] TO_PRE = TO_MAX - 1'b1;

    state_t          state;
    state_t          state_nxt;
    logic            req_s;
    logic            valid_nxt;
    logic            ack_nxt;
    logic            capture;
    logic            proto_drop;
    logic            stall;
    logic            to_hit;
    logic [TO_W-1:0] to_cnt;

    p_SSYNC2DO_C_PP u_req_sync (
        .clk  (nvdla_core_clk),
        .d    (src_req),
        .clr_ (nvdla_core_rstn),
        .q    (req_s)
    );

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A dropped request in PEND wins over a same-cycle handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_s) state_nxt = PEND;
            PEND: begin
                if (!req_s) begin
                    state_nxt = IDLE;
                end else if (dst_ready) begin
                    state_nxt = ACK;
                end
            end
            ACK:     if (!req_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_nxt  = (state_nxt == PEND);
        ack_nxt    = (state_nxt == ACK);
        capture    = (state == IDLE) && req_s;
        proto_drop = (state == PEND) && !req_s;
        stall      = (state == PEND) && !dst_ready;
        to_hit     = stall && (to_cnt >= TO_PRE);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            dst_valid <= 1'b0;
            dst_ack   <= 1'b0;
            dst_data  <= '0;
        end else begin
            dst_valid <= valid_nxt;
            dst_ack   <= ack_nxt;
            if (capture) begin
                dst_data <= src_data;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            to_cnt <= '0;
        end else if (capture) begin
            to_cnt <= '0;
        end else if (stall && (to_cnt != TO_MAX)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Sticky flags: a set condition in the same cycle overrides err_clr.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            err_proto   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (proto_drop) begin
                err_proto <= 1'b1;
            end else if (err_clr) begin
                err_proto <= 1'b0;
            end
            if (to_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: doc/nv_nvdla_sync_req_ack_ctrl.md
NV_NVDLA_SYNC_REQ_ACK_CTRL -- requirements
Module: NV_NVDLA_sync_req_ack_ctrl

Interface
REQ-001 Parameter DW, default 32, width of the transferred data word.
REQ-002 Parameter TO_W, default 8, width of the timeout counter; timeout threshold is 2^TO_W-1 cycles.
REQ-003 nvdla_core_clk  input  1  sole clock; all state on its rising edge.
REQ-004 nvdla_core_rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 src_req  input  1  four-phase request level from foreign clock domain, asynchronous.
REQ-006 src_data  input  DW  foreign-domain data, quasi-static while src_req high.
REQ-007 dst_ack  output  1  registered acknowledge level returned to the foreign domain.
REQ-008 dst_valid  output  1  local valid, registered.
REQ-009 dst_ready  input  1  local consumer ready.
REQ-010 dst_data  output  DW  captured word, registered, held until the next capture.
REQ-011 err_proto  output  1  sticky: src_req dropped before the local handshake completed.
REQ-012 err_timeout  output  1  sticky: dst_valid stalled for 2^TO_W-1 cycles.
REQ-013 err_clr  input  1  synchronous pulse clearing both sticky flags.

Function
REQ-014 src_req SHALL pass through a two-flop synchronizer; the output is req_s. No other src_* signal is synchronized.
REQ-015 FSM states SHALL be IDLE, PEND, ACK.
REQ-016 IDLE: when req_s=1, SHALL capture src_data into dst_data, assert dst_valid, go to PEND.
REQ-017 Latency: src_req first sampled high at edge E0 -> dst_valid=1 and dst_data valid after edge E2.
REQ-018 PEND: dst_valid=1. On dst_valid&dst_ready with req_s=1, SHALL deassert dst_valid, assert dst_ack, go to ACK on the same edge.
REQ-019 PEND: req_s=0 SHALL set err_proto, deassert dst_valid, go to IDLE, and leave dst_ack at 0. This takes priority over dst_ready in the same cycle.
REQ-020 ACK: dst_ack=1, dst_valid=0. On req_s=0, SHALL deassert dst_ack and go to IDLE. src_req sampled low at E0 -> dst_ack=0 after E2.
REQ-021 IDLE is re-entered only with req_s=0, so a held request is never captured twice.
REQ-022 Timeout counter SHALL clear on entry to PEND and increment each PEND cycle with dst_ready=0.
REQ-023 At all-ones the counter SHALL saturate and set err_timeout. The FSM stays in PEND.
REQ-024 err_clr SHALL clear both sticky flags. A set condition in the same cycle SHALL win over err_clr.
REQ-025 dst_data SHALL change only on the IDLE->PEND capture edge.

Reset
REQ-026 nvdla_core_rstn low SHALL immediately set the following to zero: state IDLE, dst_ack, dst_valid, dst_data, err_proto, err_timeout, the timeout counter and both synchronizer flops.
REQ-027 Reset mid-transfer (PEND or ACK) SHALL abandon the transfer. After release the FSM restarts from IDLE and re-captures if req_s is still high.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, PEND=1, ACK=2) and the default DW/TO_W constants.
REQ-029 The synchronizer SHALL be one instance of the codebase two-flop clearable synchronizer cell p_SSYNC2DO_C_PP, with clr_ tied to nvdla_core_rstn. This is the only sub-module.

Verification
REQ-030 Basic transfer: src_data=0xA5A5_1234, src_req rises, dst_ready=1 -> dst_valid high 3 edges later with dst_data=0xA5A5_1234; dst_ack next edge; src_req drops -> dst_ack low 3 edges later.
REQ-031 Backpressure: dst_ready=0 for 10 cycles then 1 -> dst_valid held 11 cycles, dst_data stable, no errors.
REQ-032 Timeout (TO_W=4): dst_ready=0 for 20 cycles -> err_timeout=1 after 15 PEND cycles; err_clr pulse while stalled -> re-set only when the counter is still saturated (set wins), otherwise clear.
REQ-033 Protocol error: src_req drops in PEND with dst_ready=1 in the same cycle -> err_proto=1, dst_ack never asserts, state IDLE.
REQ-034 Reset in ACK: assert nvdla_core_rstn low with src_req held high -> all outputs 0 at once; after release, re-capture with dst_valid=1 three edges later.
REQ-035 Back-to-back: two four-phase transfers with words 0x1 and 0x2 -> exactly two dst_valid&dst_ready handshakes, in order, no duplicates.
